mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester and the load/store requester.
- Sits between the fetch/load-store logic and the memory, replacing the dual-port arrangement.
- Serialises requests with a valid/ready handshake, tracks one outstanding access over a fixed memory latency, and routes each response back to its owner.
- Data accesses have priority; a starvation counter bounds fetch wait.

Parameters:
REGISTER_WIDTH, 32, address/data width
BYTE_WIDTH, 8, bits per byte lane; byte-enable width = REGISTER_WIDTH/BYTE_WIDTH
MEM_LATENCY, 1, cycles from mem_req_valid to mem_read_data valid; legal range >= 1
STARVE_LIMIT, 4, consecutive contested data grants before fetch is forced to win; legal range >= 1

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
fetch_req_valid  input  1  fetch request pending
fetch_req_ready  output  1  fetch request accepted this cycle
fetch_address  input  REGISTER_WIDTH  fetch byte address
fetch_resp_valid  output  1  one-cycle pulse, fetch data valid
fetch_resp_data  output  REGISTER_WIDTH  fetched instruction word
data_req_valid  input  1  load/store request pending
data_req_ready  output  1  load/store request accepted this cycle
data_address  input  REGISTER_WIDTH  load/store byte address
data_write_en  input  1  1 = store, 0 = load
data_write_data  input  REGISTER_WIDTH  store data
data_byte_enable  input  REGISTER_WIDTH/BYTE_WIDTH  byte lanes
data_resp_valid  output  1  one-cycle pulse, load data valid or store complete
data_resp_data  output  REGISTER_WIDTH  load data; 0 for stores
mem_req_valid  output  1  one-cycle memory command strobe
mem_address  output  REGISTER_WIDTH  memory address
mem_write_en  output  1  memory write strobe
mem_write_data  output  REGISTER_WIDTH  memory write data
mem_byte_enable  output  REGISTER_WIDTH/BYTE_WIDTH  memory byte lanes
mem_read_data  input  REGISTER_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_req_valid

Behaviour:

Reset:
- Clock clk; reset rst is asynchronous and active-high.
- Reset forces the FSM to IDLE, starve_count to 0, and owner to FETCH.
- All outputs go to 0, including mem_byte_enable and both resp_data buses.
- Reset mid-transaction aborts the access: no resp_valid is produced for it.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant is combinational from the valids.
  - Only fetch valid -> fetch wins.
  - Only data valid -> data wins.
  - Both valid -> data wins unless starve_count == STARVE_LIMIT, in which case fetch wins.
  - The winner's ready is 1 and the loser's ready is 0. Both readies are 0 when neither is valid.
  - On accept, register address, write_en, write_data, byte_enable and owner, then go to ISSUE.
- Ready outputs are 0 in every state other than IDLE. Only one transaction is outstanding at a time.
- ISSUE: mem_req_valid = 1 for exactly this cycle, with the registered fields on the mem_* outputs.
  - Go to RESP if MEM_LATENCY == 1, else go to WAIT.
- WAIT: a down-counter loaded with MEM_LATENCY-1; go to RESP when it reaches 0.
- RESP: owner's resp_valid = 1 for exactly one cycle.
  - Load: owner's resp_data = mem_read_data (pass-through).
  - Store: owner's resp_data = 0, but data_resp_valid still pulses.
  - The non-owner's resp_valid and resp_data stay 0. Next state is IDLE.
- mem_* outputs are 0 outside ISSUE.

Timing:
- Accept at cycle T -> mem_req_valid at T+1 -> resp_valid at T+1+MEM_LATENCY.
- Next accept is possible at T+2+MEM_LATENCY. Back-to-back throughput is one access per MEM_LATENCY+2 cycles.

Starvation counter (starve_count):
- Increments (saturating at STARVE_LIMIT) on an IDLE accept where both valids are 1 and data wins.
- Clears to 0 on any fetch accept.
- Holds otherwise, including when data is granted uncontested.

Request fields:
- Requesters must hold valid and fields stable until ready; the arbiter samples fields only on the accept cycle.
- Addresses and byte enables pass through unchecked; alignment is the requester's responsibility.
- A fetch is always a full-word read: mem_write_en = 0, mem_byte_enable = all ones.

Decomposition:
- Shared package (common): mem_owner_t enum {OWNER_FETCH, OWNER_DATA} and arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
- Reuse existing REGISTER_WIDTH/BYTE_WIDTH constants as parameter defaults.
- No sub-module; the single FSM, latency counter and starve counter fit in one module.

Test Plan:
1. Reset while in WAIT (MEM_LATENCY=3), with a fetch of 0x40 in flight -> all outputs 0 immediately, no fetch_resp_valid afterwards, next fetch of 0x44 is accepted in IDLE.
2. Fetch only, address 0x100, MEM_LATENCY=2, memory returns 0x00A00093 -> fetch_req_ready at T, mem_req_valid at T+1 with address 0x100 and byte_enable 4'b1111, fetch_resp_valid at T+3 with data 0x00A00093, data_resp_valid stays 0.
3. Store to 0x200, data 0xDEADBEEF, byte_enable 4'b0011 -> one mem_req_valid pulse with write_en=1 and lanes 4'b0011, data_resp_valid pulses with data 0.
4. Fetch and data both valid in the same IDLE cycle, STARVE_LIMIT=4 -> data wins and fetch_req_ready=0 that cycle. After the data response, fetch is accepted at the next IDLE.
5. Both held valid continuously, STARVE_LIMIT=2 -> grant order data, data, fetch, data, data, fetch; starve_count sequence 1, 2, 0.
6. Load from 0x300, MEM_LATENCY=1, mem returns 0x12345678 -> data_resp_valid at T+2 with 0x12345678. A fetch raised at T+1 gets fetch_req_ready only at T+3.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and width constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned REGISTER_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH     = 8;

  typedef enum logic {
    OWNER_FETCH,
    OWNER_DATA
  } mem_owner_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-ported memory,
// one outstanding access at a time, with data priority bounded by a starvation count.
module mem_port_arbiter #(
  parameter int unsigned REGISTER_WIDTH = mem_port_arbiter_pkg::REGISTER_WIDTH,
  parameter int unsigned BYTE_WIDTH     = mem_port_arbiter_pkg::BYTE_WIDTH,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 fetch_req_valid,
  output logic                                 fetch_req_ready,
  input  logic [REGISTER_WIDTH-1:0]            fetch_address,
  output logic                                 fetch_resp_valid,
  output logic [REGISTER_WIDTH-1:0]            fetch_resp_data,
  input  logic                                 data_req_valid,
  output logic                                 data_req_ready,
  input  logic [REGISTER_WIDTH-1:0]            data_address,
  input  logic                                 data_write_en,
  input  logic [REGISTER_WIDTH-1:0]            data_write_data,
  input  logic [REGISTER_WIDTH/BYTE_WIDTH-1:0] data_byte_enable,
  output logic                                 data_resp_valid,
  output logic [REGISTER_WIDTH-1:0]            data_resp_data,
  output logic                                 mem_req_valid,
  output logic [REGISTER_WIDTH-1:0]            mem_address,
  output logic                                 mem_write_en,
  output logic [REGISTER_WIDTH-1:0]            mem_write_data,
  output logic [REGISTER_WIDTH/BYTE_WIDTH-1:0] mem_byte_enable,
  input  logic [REGISTER_WIDTH-1:0]            mem_read_data
);
  import mem_port_arbiter_pkg::*;

  localparam int unsigned BE_WIDTH = REGISTER_WIDTH / BYTE_WIDTH;
  localparam int unsigned LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned SC_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);

  arb_state_t                state, state_next;
  mem_owner_t                owner;
  logic [REGISTER_WIDTH-1:0] addr_q;
  logic                      we_q;
  logic [REGISTER_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]       be_q;
  logic [LAT_W-1:0]          lat_cnt;
  logic [SC_W-1:0]           starve_count;
  logic                      grant_fetch;
  logic                      grant_data;

  // Readies are gated by rst so every output is 0 while reset is held.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (state == IDLE && !rst) begin
      if (fetch_req_valid && (!data_req_valid || starve_count == SC_MAX)) begin
        grant_fetch = 1'b1;
      end else if (data_req_valid) begin
        grant_data = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_fetch || grant_data) state_next = ISSUE;
      ISSUE:   state_next = (MEM_LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (lat_cnt <= LAT_W'(1)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWNER_FETCH;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      lat_cnt      <= '0;
      starve_count <= '0;
    end else begin
      state <= state_next;
      if (grant_fetch) begin
        owner        <= OWNER_FETCH;
        addr_q       <= fetch_address;
        we_q         <= 1'b0;
        wdata_q      <= '0;
        be_q         <= '1;
        starve_count <= '0;
      end else if (grant_data) begin
        owner   <= OWNER_DATA;
        addr_q  <= data_address;
        we_q    <= data_write_en;
        wdata_q <= data_write_data;
        be_q    <= data_byte_enable;
        // A contested data win implies starve_count < SC_MAX, so this saturates.
        if (fetch_req_valid) starve_count <= starve_count + 1'b1;
      end
      if (state == ISSUE) begin
        lat_cnt <= LAT_LOAD;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    fetch_req_ready  = grant_fetch;
    data_req_ready   = grant_data;
    fetch_resp_valid = 1'b0;
    fetch_resp_data  = '0;
    data_resp_valid  = 1'b0;
    data_resp_data   = '0;
    mem_req_valid    = 1'b0;
    mem_address      = '0;
    mem_write_en     = 1'b0;
    mem_write_data   = '0;
    mem_byte_enable  = '0;
    if (state == ISSUE) begin
      mem_req_valid   = 1'b1;
      mem_address     = addr_q;
      mem_write_en    = we_q;
      mem_write_data  = wdata_q;
      mem_byte_enable = be_q;
    end
    if (state == RESP) begin
      if (owner == OWNER_FETCH) begin
        fetch_resp_valid = 1'b1;
        fetch_resp_data  = mem_read_data;
      end else begin
        data_resp_valid = 1'b1;
        data_resp_data  = we_q ? '0 : mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (latency 1/2/3) share stimulus.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req_valid = 1'b0;
  logic [31:0] fetch_address = '0;
  logic        data_req_valid = 1'b0;
  logic [31:0] data_address = '0;
  logic        data_write_en = 1'b0;
  logic [31:0] data_write_data = '0;
  logic [3:0]  data_byte_enable = '0;
  logic [31:0] mem_read_data = '0;

  logic        fetch_req_ready  [3];
  logic        fetch_resp_valid [3];
  logic [31:0] fetch_resp_data  [3];
  logic        data_req_ready   [3];
  logic        data_resp_valid  [3];
  logic [31:0] data_resp_data   [3];
  logic        mem_req_valid    [3];
  logic [31:0] mem_address      [3];
  logic        mem_write_en     [3];
  logic [31:0] mem_write_data   [3];
  logic [3:0]  mem_byte_enable  [3];

  int checks = 0;
  int failures = 0;

  bit exp_fetch_win [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  int exp_starve    [6] = '{1, 2, 0, 1, 2, 0};

  always #5 clk = ~clk;

  // Instance g: MEM_LATENCY = g+1; STARVE_LIMIT = 2 for instance 1, else 4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .REGISTER_WIDTH(32),
      .BYTE_WIDTH    (8),
      .MEM_LATENCY   (g + 1),
      .STARVE_LIMIT  ((g == 1) ? 2 : 4)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_req_valid (fetch_req_valid),
      .fetch_req_ready (fetch_req_ready[g]),
      .fetch_address   (fetch_address),
      .fetch_resp_valid(fetch_resp_valid[g]),
      .fetch_resp_data (fetch_resp_data[g]),
      .data_req_valid  (data_req_valid),
      .data_req_ready  (data_req_ready[g]),
      .data_address    (data_address),
      .data_write_en   (data_write_en),
      .data_write_data (data_write_data),
      .data_byte_enable(data_byte_enable),
      .data_resp_valid (data_resp_valid[g]),
      .data_resp_data  (data_resp_data[g]),
      .mem_req_valid   (mem_req_valid[g]),
      .mem_address     (mem_address[g]),
      .mem_write_en    (mem_write_en[g]),
      .mem_write_data  (mem_write_data[g]),
      .mem_byte_enable (mem_byte_enable[g]),
      .mem_read_data   (mem_read_data)
    );
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fetch_req_valid = 1'b0;
    data_req_valid  = 1'b0;
    data_write_en   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [137:0] v;
    @(negedge clk);
    rst = 1'b1;
    fetch_req_valid = 1'b0;
    data_req_valid  = 1'b0;
    mem_read_data   = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      v = {fetch_req_ready[k], fetch_resp_valid[k], fetch_resp_data[k], data_req_ready[k],
           data_resp_valid[k], data_resp_data[k], mem_req_valid[k], mem_address[k],
           mem_write_en[k], mem_write_data[k], mem_byte_enable[k]};
      checks++;
      if (v !== '0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got=%h want=0", k, v);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [137:0] v;
    int seen = 0;
    do_reset();
    mem_read_data   = 32'hCAFE_F00D;
    fetch_req_valid = 1'b1;
    fetch_address   = 32'h40;
    #1;
    checks++;
    if (fetch_req_ready[2] !== 1'b1) begin
      failures++; $display("FAIL midreset_accept got=%b want=1", fetch_req_ready[2]);
    end
    @(negedge clk);
    fetch_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    v = {fetch_req_ready[2], fetch_resp_valid[2], fetch_resp_data[2], data_req_ready[2],
         data_resp_valid[2], data_resp_data[2], mem_req_valid[2], mem_address[2],
         mem_write_en[2], mem_write_data[2], mem_byte_enable[2]};
    checks++;
    if (v !== '0) begin
      failures++; $display("FAIL midreset_outputs got=%h want=0", v);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (fetch_resp_valid[2] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL midreset_no_resp got=%0d pulses want=0", seen);
    end
    fetch_req_valid = 1'b1;
    fetch_address   = 32'h44;
    #1;
    checks++;
    if (fetch_req_ready[2] !== 1'b1) begin
      failures++; $display("FAIL midreset_next_accept got=%b want=1", fetch_req_ready[2]);
    end
    @(negedge clk);
    fetch_req_valid = 1'b0;
    #1;
    checks++;
    if (mem_req_valid[2] !== 1'b1 || mem_address[2] !== 32'h44) begin
      failures++;
      $display("FAIL midreset_next_issue got=%b/%h want=1/00000044", mem_req_valid[2], mem_address[2]);
    end
  endtask

  task automatic test_fetch_only();
    do_reset();
    mem_read_data   = 32'h00A0_0093;
    fetch_req_valid = 1'b1;
    fetch_address   = 32'h100;
    #1;
    checks++;
    if (fetch_req_ready[1] !== 1'b1 || data_req_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL fetch_ready got=%b/%b want=1/0", fetch_req_ready[1], data_req_ready[1]);
    end
    @(negedge clk);
    fetch_req_valid = 1'b0;
    #1;
    checks++;
    if (mem_req_valid[1] !== 1'b1 || mem_address[1] !== 32'h100 ||
        mem_byte_enable[1] !== 4'b1111 || mem_write_en[1] !== 1'b0) begin
      failures++;
      $display("FAIL fetch_issue got=%b/%h/%b/%b want=1/00000100/1111/0",
               mem_req_valid[1], mem_address[1], mem_byte_enable[1], mem_write_en[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_req_valid[1] !== 1'b0 || fetch_resp_valid[1] !== 1'b0) begin
      failures++;
      $display("FAIL fetch_wait got=%b/%b want=0/0", mem_req_valid[1], fetch_resp_valid[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (fetch_resp_valid[1] !== 1'b1 || fetch_resp_data[1] !== 32'h00A0_0093 ||
        data_resp_valid[1] !== 1'b0) begin
      failures++;
      $display("FAIL fetch_resp got=%b/%h/%b want=1/00a00093/0",
               fetch_resp_valid[1], fetch_resp_data[1], data_resp_valid[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (fetch_resp_valid[1] !== 1'b0 || fetch_resp_data[1] !== 32'h0) begin
      failures++;
      $display("FAIL fetch_resp_pulse got=%b/%h want=0/0", fetch_resp_valid[1], fetch_resp_data[1]);
    end
  endtask

  task automatic test_store();
    do_reset();
    mem_read_data    = 32'h5555_5555;
    data_req_valid   = 1'b1;
    data_write_en    = 1'b1;
    data_address     = 32'h200;
    data_write_data  = 32'hDEAD_BEEF;
    data_byte_enable = 4'b0011;
    #1;
    checks++;
    if (data_req_ready[1] !== 1'b1) begin
      failures++; $display("FAIL store_ready got=%b want=1", data_req_ready[1]);
    end
    @(negedge clk);
    data_req_valid = 1'b0;
    data_write_en  = 1'b0;
    #1;
    checks++;
    if (mem_req_valid[1] !== 1'b1 || mem_write_en[1] !== 1'b1 || mem_address[1] !== 32'h200 ||
        mem_write_data[1] !== 32'hDEAD_BEEF || mem_byte_enable[1] !== 4'b0011) begin
      failures++;
      $display("FAIL store_issue got=%b/%b/%h/%h/%b want=1/1/00000200/deadbeef/0011",
               mem_req_valid[1], mem_write_en[1], mem_address[1], mem_write_data[1],
               mem_byte_enable[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_req_valid[1] !== 1'b0 || mem_write_en[1] !== 1'b0) begin
      failures++;
      $display("FAIL store_single_pulse got=%b/%b want=0/0", mem_req_valid[1], mem_write_en[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (data_resp_valid[1] !== 1'b1 || data_resp_data[1] !== 32'h0 || fetch_resp_valid[1] !== 1'b0) begin
      failures++;
      $display("FAIL store_resp got=%b/%h/%b want=1/00000000/0",
               data_resp_valid[1], data_resp_data[1], fetch_resp_valid[1]);
    end
  endtask

  task automatic test_contention();
    do_reset();
    mem_read_data    = 32'h0BAD_0BAD;
    fetch_req_valid  = 1'b1;
    fetch_address    = 32'h500;
    data_req_valid   = 1'b1;
    data_write_en    = 1'b0;
    data_address     = 32'h600;
    data_byte_enable = 4'b1111;
    #1;
    checks++;
    if (data_req_ready[2] !== 1'b1 || fetch_req_ready[2] !== 1'b0) begin
      failures++;
      $display("FAIL contend_grant got=d%b/f%b want=d1/f0", data_req_ready[2], fetch_req_ready[2]);
    end
    @(negedge clk);
    data_req_valid = 1'b0;
    #1;
    checks++;
    if (mem_address[2] !== 32'h600 || fetch_req_ready[2] !== 1'b0) begin
      failures++;
      $display("FAIL contend_issue got=%h/%b want=00000600/0", mem_address[2], fetch_req_ready[2]);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (data_resp_valid[2] !== 1'b1 || data_resp_data[2] !== 32'h0BAD_0BAD || fetch_req_ready[2] !== 1'b0) begin
      failures++;
      $display("FAIL contend_data_resp got=%b/%h/%b want=1/0bad0bad/0",
               data_resp_valid[2], data_resp_data[2], fetch_req_ready[2]);
    end
    @(negedge clk); #1;
    checks++;
    if (fetch_req_ready[2] !== 1'b1) begin
      failures++; $display("FAIL contend_fetch_next got=%b want=1", fetch_req_ready[2]);
    end
    @(negedge clk);
    fetch_req_valid = 1'b0;
    #1;
    checks++;
    if (mem_address[2] !== 32'h500 || mem_write_en[2] !== 1'b0) begin
      failures++;
      $display("FAIL contend_fetch_issue got=%h/%b want=00000500/0", mem_address[2], mem_write_en[2]);
    end
  endtask

  task automatic test_starvation();
    int n = 0;
    int budget = 0;
    bit fw;
    do_reset();
    fetch_req_valid  = 1'b1;
    fetch_address    = 32'h800;
    data_req_valid   = 1'b1;
    data_write_en    = 1'b0;
    data_address     = 32'h900;
    data_byte_enable = 4'b1111;
    #1;
    while (n < 6 && budget < 60) begin
      if (fetch_req_ready[1] === 1'b1 || data_req_ready[1] === 1'b1) begin
        fw = fetch_req_ready[1];
        checks++;
        if (fw !== exp_fetch_win[n]) begin
          failures++;
          $display("FAIL starve_grant idx=%0d fetch_won=%b want=%b", n, fw, exp_fetch_win[n]);
        end
        @(negedge clk); #1;
        budget++;
        checks++;
        if (int'(g_dut[1].u_dut.starve_count) != exp_starve[n]) begin
          failures++;
          $display("FAIL starve_count idx=%0d got=%0d want=%0d", n,
                   g_dut[1].u_dut.starve_count, exp_starve[n]);
        end
        n++;
      end else begin
        @(negedge clk); #1;
        budget++;
      end
    end
    checks++;
    if (n != 6) begin
      failures++; $display("FAIL starve_timeout grants=%0d want=6", n);
    end
    fetch_req_valid = 1'b0;
    data_req_valid  = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_read_data    = 32'h1234_5678;
    data_req_valid   = 1'b1;
    data_write_en    = 1'b0;
    data_address     = 32'h300;
    data_byte_enable = 4'b1111;
    #1;
    checks++;
    if (data_req_ready[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_load_ready got=%b want=1", data_req_ready[0]);
    end
    @(negedge clk);
    data_req_valid  = 1'b0;
    fetch_req_valid = 1'b1;
    fetch_address   = 32'h700;
    #1;
    checks++;
    if (mem_req_valid[0] !== 1'b1 || mem_address[0] !== 32'h300 || fetch_req_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_issue got=%b/%h/%b want=1/00000300/0",
               mem_req_valid[0], mem_address[0], fetch_req_ready[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (data_resp_valid[0] !== 1'b1 || data_resp_data[0] !== 32'h1234_5678 ||
        fetch_req_ready[0] !== 1'b0 || fetch_resp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_load_resp got=%b/%h/%b/%b want=1/12345678/0/0", data_resp_valid[0],
               data_resp_data[0], fetch_req_ready[0], fetch_resp_valid[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (fetch_req_ready[0] !== 1'b1 || data_resp_valid[0] !== 1'b0 || data_resp_data[0] !== 32'h0) begin
      failures++;
      $display("FAIL b2b_fetch_ready got=%b/%b/%h want=1/0/00000000",
               fetch_req_ready[0], data_resp_valid[0], data_resp_data[0]);
    end
    @(negedge clk);
    fetch_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_fetch_only();
    test_store();
    test_contention();
    test_starvation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
